// File: rtl/mii_uart_arb.sv
// Shares one UART transmitter between two buffered byte streams. Whole frames are
// forwarded round-robin, and each frame is prefixed by a per-port tag byte.
module mii_uart_arb #(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] HDR_BASE = 8'hA0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] wr_en,
  input  logic [7:0] wr_data0,
  input  logic [7:0] wr_data1,
  input  logic [1:0] wr_last,
  input  logic       uart_active,
  output logic       uart_dv,
  output logic [7:0] uart_d,
  output logic [1:0] grant,
  output logic [1:0] ovf,
  output logic       busy
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, FETCH} state_t;

  state_t     state_reg;
  logic       owner_reg;
  logic       last_grant_reg;
  logic       last_flag_reg;
  logic [1:0] nonempty;
  logic [1:0] pop;
  logic [8:0] head [2];
  logic [7:0] wdata [2];
  logic       pick;

  assign wdata[0] = wr_data0;
  assign wdata[1] = wr_data1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [8:0]    mem [DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [AW:0]   count_reg;
      logic          ovf_reg;
      logic          push;

      // A full FIFO drops the write even if it pops in the same cycle.
      assign push         = wr_en[gi] && (count_reg != FULL);
      assign nonempty[gi] = (count_reg != '0);
      assign pop[gi]      = (state_reg == FETCH) && (owner_reg == 1'(gi)) && nonempty[gi];
      assign head[gi]     = mem[rd_ptr_reg];

      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr_reg] <= {wr_last[gi], wdata[gi]};
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          ovf_reg    <= 1'b0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
          if (wr_en[gi] && !push) ovf_reg <= 1'b1;
          case ({push, pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  assign ovf = {g_fifo[1].ovf_reg, g_fifo[0].ovf_reg};

  // On a tie the port that did not own the previous frame wins.
  assign pick = (nonempty == 2'b11) ? ~last_grant_reg : nonempty[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      last_flag_reg  <= 1'b0;
      uart_dv        <= 1'b0;
      uart_d         <= '0;
      grant          <= '0;
      busy           <= 1'b0;
    end else begin
      uart_dv <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|nonempty) begin
            owner_reg     <= pick;
            grant         <= pick ? 2'b10 : 2'b01;
            uart_dv       <= 1'b1;
            uart_d        <= HDR_BASE + {7'd0, pick};
            last_flag_reg <= 1'b0;
            busy          <= 1'b1;
            state_reg     <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (uart_active) state_reg <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!uart_active) begin
            if (last_flag_reg) begin
              state_reg      <= IDLE;
              grant          <= '0;
              busy           <= 1'b0;
              last_grant_reg <= owner_reg;
            end else begin
              state_reg <= FETCH;
            end
          end
        end
        FETCH: begin
          // The grant is held while the owner's FIFO is empty.
          if (nonempty[owner_reg]) begin
            uart_dv       <= 1'b1;
            uart_d        <= head[owner_reg][7:0];
            last_flag_reg <= head[owner_reg][8];
            state_reg     <= WAIT_HI;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
